vga_timing_gen: RTL

Parametrised raster timing generator, the successor to the fixed 640x480 hsync/vsync controller pair. A single block produces hsync, vsync, data-enable, pixel coordinates and per-line/per-frame strobes for any timing set, with programmable sync polarity and a pixel-clock enable. It sits between the power-on reset and the game/pixel logic (paddle, ball). Its `vblank_start` strobe replaces ad-hoc update sequencing.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 42 ++++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing types and defaults for the raster timing generator.
// Default set is 640x480@60 with negative sync polarity.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 640, front: 16, sync: 96, back: 48};
    localparam vga_timing_t VGA_640X480_V = '{active: 480, front: 10, sync: 2, back: 33};

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int unsigned timing_total(input vga_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with active/sync segment decode.
// Segment order along the axis is active, front porch, sync, back porch.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 2,
    parameter int unsigned FRONT  = 1,
    parameter int unsigned SYNC   = 1,
    parameter int unsigned BACK   = 1,
    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK,
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clck,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FRONT + SYNC);

    if (ACTIVE < 2 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
        $error("vga_axis_counter: ACTIVE must be >= 2 and porch/sync lengths >= 1");
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            pos <= '0;
        end else if (step) begin
            pos <= (pos == LAST) ? '0 : pos + W'(1);
        end
    end

    // Decodes describe the position about to be emitted, not the one on the outputs.
    assign wrap      = step && (pos == LAST);
    assign in_active = pos < ACT_END;
    assign in_sync   = (pos >= SYNC_BEG) && (pos < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered syncs, data enable, coordinates,
// one-cycle line/frame/vblank strobes and a completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_640X480_H.active,
    parameter int unsigned H_FRONT   = VGA_640X480_H.front,
    parameter int unsigned H_SYNC    = VGA_640X480_H.sync,
    parameter int unsigned H_BACK    = VGA_640X480_H.back,
    parameter int unsigned V_ACTIVE  = VGA_640X480_V.active,
    parameter int unsigned V_FRONT   = VGA_640X480_V.front,
    parameter int unsigned V_SYNC    = VGA_640X480_V.sync,
    parameter int unsigned V_BACK    = VGA_640X480_V.back,
    parameter logic        HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        VSYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic                          clck,
    input  logic                          reset,
    input  logic                          pix_en,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          active,
    output logic [$clog2(H_ACTIVE)-1:0]   x,
    output logic [$clog2(V_ACTIVE)-1:0]   y,
    output logic                          line_start,
    output logic                          frame_start,
    output logic                          vblank_start,
    output logic [7:0]                    frame_count
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);
    localparam int unsigned HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);

    localparam logic [VW-1:0] VBLANK_LINE = VW'(V_ACTIVE);

    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clck      (clck),
        .reset     (reset),
        .step      (pix_en),
        .pos       (h_pos),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clck      (clck),
        .reset     (reset),
        .step      (h_wrap),
        .pos       (v_pos),
        .wrap      (v_wrap),
        .in_active (v_active),
        .in_sync   (v_sync)
    );

    always_ff @(posedge clck) begin
        if (reset) begin
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
            active       <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            // Strobes fall on any cycle without a tick so they stay one clock wide.
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_en) begin
                hsync        <= h_sync ? HSYNC_POL : ~HSYNC_POL;
                vsync        <= v_sync ? VSYNC_POL : ~VSYNC_POL;
                active       <= h_active && v_active;
                x            <= (h_active && v_active) ? h_pos[XW-1:0] : '0;
                y            <= v_active ? v_pos[YW-1:0] : '0;
                line_start   <= h_pos == '0;
                frame_start  <= (h_pos == '0) && (v_pos == '0);
                vblank_start <= (h_pos == '0) && (v_pos == VBLANK_LINE);
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule
